// File: rtl/scan_sram_bridge.sv
// Scan-chain access path to the single-port SRAM.
// Loads serial words into memory and dumps memory words serially, LSB first.
module scan_sram_bridge #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 2048,
  localparam int AW   = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_wr,
  input  logic             start_rd,
  input  logic [AW-1:0]    base_addr,
  input  logic [AW:0]      num_words,
  input  logic             sin_valid,
  input  logic             sin_data,
  output logic             sin_ready,
  output logic             sout_valid,
  output logic             sout_data,
  input  logic             sout_ready,
  output logic             ram_wen,
  output logic [AW-1:0]    ram_waddr,
  output logic [WIDTH-1:0] ram_wdata,
  output logic             ram_ren,
  output logic [AW-1:0]    ram_raddr,
  input  logic [WIDTH-1:0] ram_rdata,
  input  logic             ram_ready,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] BLAST = CW'(WIDTH - 1);
  localparam logic [AW-1:0] ALAST = AW'(SIZE - 1);
  localparam logic [AW:0]   ONE   = (AW+1)'(1);

  typedef enum logic [2:0] {
    IDLE, WR_SHIFT, WR_COMMIT, RD_REQ, RD_WAIT, RD_SHIFT, DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic [AW-1:0]    addr;
  logic [AW:0]      remaining;
  logic [AW-1:0]    addr_nxt;
  logic             last;

  // Explicit wrap so non-power-of-2 depths work.
  assign addr_nxt = (addr == ALAST) ? '0 : addr + 1'b1;
  assign last     = (remaining == ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      addr      <= '0;
      remaining <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_wr || start_rd) begin
            addr      <= base_addr;
            remaining <= num_words;
            bit_cnt   <= '0;
            if (num_words == '0) state <= DONE;
            else if (start_wr)   state <= WR_SHIFT;
            else                 state <= RD_REQ;
          end
        end
        WR_SHIFT: begin
          if (sin_valid) begin
            shreg   <= {sin_data, shreg[WIDTH-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BLAST) state <= WR_COMMIT;
          end
        end
        WR_COMMIT: begin
          addr      <= addr_nxt;
          remaining <= remaining - 1'b1;
          bit_cnt   <= '0;
          state     <= last ? DONE : WR_SHIFT;
        end
        RD_REQ: state <= RD_WAIT;
        RD_WAIT: begin
          if (ram_ready) begin
            shreg <= ram_rdata;
            state <= RD_SHIFT;
          end
        end
        RD_SHIFT: begin
          if (sout_ready) begin
            shreg   <= {1'b0, shreg[WIDTH-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BLAST) begin
              addr      <= addr_nxt;
              remaining <= remaining - 1'b1;
              bit_cnt   <= '0;
              state     <= last ? DONE : RD_REQ;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign sin_ready  = (state == WR_SHIFT);
  assign sout_valid = (state == RD_SHIFT);
  assign sout_data  = (state == RD_SHIFT) & shreg[0];
  assign ram_wen    = (state == WR_COMMIT);
  assign ram_waddr  = addr;
  assign ram_wdata  = shreg;
  assign ram_ren    = (state == RD_REQ);
  assign ram_raddr  = addr;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

endmodule

// File: tb/tb_scan_sram_bridge.sv
// Randomised bench for scan_sram_bridge with a behavioural SRAM
// and a word-level reference model of loads and dumps.
module tb_scan_sram_bridge;

  localparam int W  = 32;
  localparam int SZ = 2048;
  localparam int AW = 11;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          start_wr = 0, start_rd = 0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   num_words = '0;
  logic          sin_valid = 0, sin_data = 0, sin_ready;
  logic          sout_valid, sout_data, sout_ready = 0;
  logic          ram_wen, ram_ren, ram_ready = 0;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [W-1:0]  ram_wdata, ram_rdata = '0;
  logic          busy, done;

  scan_sram_bridge #(.WIDTH(W), .SIZE(SZ)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_wr(start_wr), .start_rd(start_rd),
    .base_addr(base_addr), .num_words(num_words),
    .sin_valid(sin_valid), .sin_data(sin_data), .sin_ready(sin_ready),
    .sout_valid(sout_valid), .sout_data(sout_data), .sout_ready(sout_ready),
    .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_ren(ram_ren), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .ram_ready(ram_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [W-1:0] mem [SZ];
  logic [W-1:0] ref_mem [SZ];

  int cyc = 0;
  int sent = 0;
  int done_cnt = 0;
  int commit_bad = 0;
  int first_ren = -1;
  int first_sv = -1;
  int vprob = 100;
  int rprob = 100;
  bit bitq[$];
  bit outq[$];
  logic [AW-1:0] wq_a[$];
  logic [W-1:0]  wq_d[$];
  logic [AW-1:0] rq[$];
  logic [W-1:0]  wsrc[$];
  logic          ren_prev = 0;
  logic [AW-1:0] raddr_prev = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitors and the 1-cycle SRAM model, all away from the active edge.
  always @(negedge clk) begin
    if (ram_wen) begin
      wq_a.push_back(ram_waddr);
      wq_d.push_back(ram_wdata);
      mem[ram_waddr] = ram_wdata;
      if (sin_ready) commit_bad++;
    end
    if (ram_ren) begin
      rq.push_back(ram_raddr);
      if (first_ren < 0) first_ren = cyc;
    end
    ram_ready = ren_prev;
    ram_rdata = ren_prev ? mem[raddr_prev] : W'($urandom);
    ren_prev = ram_ren & rst_n;
    raddr_prev = ram_raddr;
    if (sout_valid && first_sv < 0) first_sv = cyc;
    if (sout_valid && sout_ready) outq.push_back(sout_data);
    if (done) done_cnt++;
    if (sin_valid && sin_ready) sent++;
  end

  always @(posedge clk) begin
    #1;
    if (sent < bitq.size()) begin
      sin_data  = bitq[sent];
      sin_valid = (vprob >= 100) || ($urandom_range(99) < vprob);
    end else begin
      sin_data  = 0;
      sin_valid = 0;
    end
    sout_ready = (rprob >= 100) || ($urandom_range(99) < rprob);
  end

  task automatic wait_done(input int d0);
    int t;
    t = 0;
    while (done_cnt == d0 && t < 20000) begin
      @(posedge clk);
      t++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("done_pulses", 64'(done_cnt - d0), 64'd1);
    if (done_cnt == d0) begin
      rst_n = 0;
      @(posedge clk);
      #1 rst_n = 1;
    end
  endtask

  int c0;

  task automatic xfer(input bit wr, input int base, input int num,
                      input int vp, input int rp);
    logic [AW-1:0] ea[$];
    logic [W-1:0]  ed[$];
    logic [W-1:0]  w, got;
    int d0, a;
    vprob = vp;
    rprob = rp;
    wq_a.delete(); wq_d.delete(); rq.delete(); outq.delete();
    first_ren = -1;
    first_sv = -1;
    d0 = done_cnt;
    bitq.delete();
    sent = 0;
    for (int i = 0; i < num; i++) begin
      a = (base + i) % SZ;
      ea.push_back(AW'(a));
      if (wr) begin
        w = (wsrc.size() > 0) ? wsrc.pop_front() : W'($urandom);
        ref_mem[a] = w;
        for (int b = 0; b < W; b++) bitq.push_back(w[b]);
      end
      ed.push_back(ref_mem[a]);
    end
    @(posedge clk);
    #1;
    start_wr = wr;
    start_rd = !wr;
    base_addr = AW'(base);
    num_words = (AW+1)'(num);
    c0 = cyc;
    @(posedge clk);
    #1;
    start_wr = 0;
    start_rd = 0;
    wait_done(d0);
    if (wr) begin
      chk("wr_count", 64'(wq_a.size()), 64'(num));
      for (int i = 0; i < num && i < wq_a.size(); i++) begin
        chk("wr_addr", 64'(wq_a[i]), 64'(ea[i]));
        chk("wr_data", 64'(wq_d[i]), 64'(ed[i]));
      end
    end else begin
      chk("rd_bits", 64'(outq.size()), 64'(num * W));
      chk("rd_reqs", 64'(rq.size()), 64'(num));
      for (int i = 0; i < num && i < rq.size(); i++)
        chk("rd_addr", 64'(rq[i]), 64'(ea[i]));
      for (int i = 0; i < num && (i + 1) * W <= outq.size(); i++) begin
        got = '0;
        for (int b = 0; b < W; b++) got[b] = outq[i * W + b];
        chk("rd_word", 64'(got), 64'(ed[i]));
      end
    end
  endtask

  initial begin
    int d0;
    for (int i = 0; i < SZ; i++) begin
      mem[i] = W'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[7] = 32'hA5A5_0F0F;
    ref_mem[7] = 32'hA5A5_0F0F;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl",
        64'({busy, done, sin_ready, sout_valid, sout_data, ram_wen, ram_ren}),
        64'd0);
    chk("rst_wbus", 64'({ram_waddr, ram_wdata}), 64'd0);
    rst_n = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_busy", 64'(busy), 64'd0);

    // Zero-length load: one busy cycle carrying the done pulse.
    wq_a.delete();
    @(posedge clk);
    #1;
    start_wr = 1;
    num_words = '0;
    base_addr = 11'd9;
    @(posedge clk);
    #1;
    start_wr = 0;
    chk("zero_busy", 64'(busy), 64'd1);
    chk("zero_done", 64'(done), 64'd1);
    @(posedge clk);
    #1;
    chk("zero_idle", 64'({busy, done}), 64'd0);
    chk("zero_nowr", 64'(wq_a.size()), 64'd0);

    // Fixed two-word load.
    wsrc.push_back(32'hDEAD_BEEF);
    wsrc.push_back(32'h1234_5678);
    commit_bad = 0;
    xfer(1, 5, 2, 100, 100);
    chk("commit_rdy", 64'(commit_bad), 64'd0);

    // One-word dump with stalls, plus latency.
    xfer(0, 7, 1, 100, 100);
    chk("ren_lat", 64'(first_ren - c0), 64'd1);
    chk("sv_lat", 64'(first_sv - c0), 64'd3);
    xfer(0, 7, 1, 100, 40);

    // Address wrap on read and on write.
    xfer(0, SZ - 1, 3, 100, 70);
    xfer(1, SZ - 2, 3, 60, 100);
    xfer(0, SZ - 2, 3, 100, 100);

    for (int n = 0; n < 10; n++) begin
      int base;
      base = $urandom_range(1) ? SZ - 1 - $urandom_range(2)
                               : $urandom_range(SZ - 1);
      xfer(1'($urandom_range(1)), base, $urandom_range(4),
           $urandom_range(100, 30), $urandom_range(100, 30));
    end

    // Simultaneous starts, then a start while busy.
    wq_a.delete(); wq_d.delete(); rq.delete();
    bitq.delete();
    sent = 0;
    vprob = 100;
    wsrc.push_back(32'h0BAD_F00D);
    for (int b = 0; b < W; b++) bitq.push_back(wsrc[0][b]);
    ref_mem[20] = wsrc.pop_front();
    d0 = done_cnt;
    @(posedge clk);
    #1;
    start_wr = 1;
    start_rd = 1;
    base_addr = 11'd20;
    num_words = 12'd1;
    @(posedge clk);
    #1;
    start_wr = 0;
    start_rd = 0;
    repeat (4) @(posedge clk);
    #1;
    start_rd = 1;
    base_addr = 11'd30;
    @(posedge clk);
    #1;
    start_rd = 0;
    wait_done(d0);
    chk("both_wr", 64'(wq_a.size()), 64'd1);
    if (wq_a.size() > 0) chk("both_data", 64'(wq_d[0]), 64'h0BAD_F00D);
    chk("busy_rd", 64'(rq.size()), 64'd0);

    // Reset in the middle of a word.
    wq_a.delete();
    bitq.delete();
    sent = 0;
    for (int b = 0; b < 2 * W; b++) bitq.push_back(1'($urandom));
    @(posedge clk);
    #1;
    start_wr = 1;
    base_addr = 11'd40;
    num_words = 12'd2;
    @(posedge clk);
    #1;
    start_wr = 0;
    for (int t = 0; t < 200 && sent < 10; t++) begin
      @(posedge clk);
      #1;
    end
    chk("rst_bits", 64'(sent), 64'd10);
    rst_n = 0;
    #1;
    chk("arst_ctrl",
        64'({busy, done, sin_ready, sout_valid, sout_data, ram_wen, ram_ren}),
        64'd0);
    chk("arst_bus", 64'({ram_waddr, ram_raddr, ram_wdata}), 64'd0);
    bitq.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("arst_idle", 64'(busy), 64'd0);
    chk("arst_nowr", 64'(wq_a.size()), 64'd0);

    // Memory still serves normally after the reset.
    xfer(0, 5, 2, 100, 80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
